// File: rtl/servo_sched_pkg.sv
// Shared types and constants for the servo job scheduler.
// Latency: n/a (types, constants and pure decode functions only).
// Backpressure: n/a.
package servo_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SPIN  = 3'd2,
        ST_PUSH  = 3'd3,
        ST_PULL  = 3'd4,
        ST_FAULT = 3'd5
    } sched_state_t;

    // Instruction word layout
    localparam int INSTR_W        = 10;
    localparam int INSTR_MODE     = 9;   // 0 = full sort job, 1 = maintenance
    localparam int INSTR_SPIN_SEL = 8;   // maintenance: 1 = spin only
    localparam int INSTR_DIR      = 7;   // maintenance track move: 1 = push, 0 = pull
    localparam int INSTR_POS_MSB  = 7;
    localparam int INSTR_POS_LSB  = 0;

    localparam logic [1:0] FAULT_NONE = 2'b00;
    localparam logic [1:0] FAULT_SPIN = 2'b01;
    localparam logic [1:0] FAULT_PUSH = 2'b10;
    localparam logic [1:0] FAULT_PULL = 2'b11;

    localparam logic [7:0] TRACK_FWD_DEF = 8'hFF;
    localparam logic [7:0] TRACK_BWD_DEF = 8'h00;

    // Sort jobs chain SPIN -> PUSH -> PULL; maintenance jobs run one motion only.
    function automatic logic is_sort_job(input logic [INSTR_W-1:0] instr);
        return ~instr[INSTR_MODE];
    endfunction

    function automatic sched_state_t first_motion(input logic [INSTR_W-1:0] instr);
        sched_state_t s;
        s = ST_PULL;
        if (!instr[INSTR_MODE] || instr[INSTR_SPIN_SEL]) begin
            s = ST_SPIN;
        end else if (instr[INSTR_DIR]) begin
            s = ST_PUSH;
        end
        return s;
    endfunction

    function automatic logic [1:0] fault_code_for(input sched_state_t s);
        logic [1:0] c;
        case (s)
            ST_SPIN: c = FAULT_SPIN;
            ST_PUSH: c = FAULT_PUSH;
            ST_PULL: c = FAULT_PULL;
            default: c = FAULT_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/sched_cmd_fifo.sv
// Small synchronous FIFO holding queued servo instructions, with occupancy count and flush.
// Latency: a word pushed at edge N is visible on pop_data after edge N (show-ahead head).
// Backpressure: push ignored when full, pop ignored when empty; the producer must watch count.
// Ports: clk, reset (sync, active-high), flush, push/push_data, pop/pop_data, count.
module sched_cmd_fifo
    import servo_sched_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = INSTR_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && (count != CW'(DEPTH));
    assign do_pop   = pop && (count != '0);
    assign pop_data = mem[rd_ptr];

    // Storage has no reset; only the pointers/count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/servo_job_scheduler.sv
// Queues 10-bit servo instructions and runs them one at a time on the turntable/track drivers.
// Latency: accept at edge N -> FETCH after N+1 -> motion outputs after N+2; plant events add 2 sync cycles.
// Backpressure: cmd_ready low when the queue is full or a fault is latched; held commands are not lost.
// Ports: cmd_valid/cmd_data/cmd_ready instruction input; colour_correct/extended/retracted async plant
//        events; fault_clear; turntable_en/pos, track_en/pos driver controls; busy, job_done, fault,
//        fault_code, queue_count status.
module servo_job_scheduler
    import servo_sched_pkg::*;
#(
    parameter int         DEPTH          = 4,
    parameter int         TIMEOUT_CYCLES = 50_000_000,
    parameter logic [7:0] TRACK_FWD      = TRACK_FWD_DEF,
    parameter logic [7:0] TRACK_BWD      = TRACK_BWD_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    input  logic [INSTR_W-1:0]     cmd_data,
    output logic                   cmd_ready,
    input  logic                   colour_correct,
    input  logic                   extended,
    input  logic                   retracted,
    input  logic                   fault_clear,
    output logic                   turntable_en,
    output logic [7:0]             turntable_pos,
    output logic                   track_en,
    output logic [7:0]             track_pos,
    output logic                   busy,
    output logic                   job_done,
    output logic                   fault,
    output logic [1:0]             fault_code,
    output logic [$clog2(DEPTH):0] queue_count
);

    localparam int               CW       = $clog2(DEPTH) + 1;
    localparam int               TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    // ------------------------------------------------------------------
    // Two-flop synchronisers for the asynchronous plant signals
    // ------------------------------------------------------------------
    logic [1:0] colour_sync;
    logic [1:0] ext_sync;
    logic [1:0] ret_sync;
    logic       colour_s;
    logic       extended_s;
    logic       retracted_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            colour_sync <= '0;
            ext_sync    <= '0;
            ret_sync    <= '0;
        end else begin
            colour_sync <= {colour_sync[0], colour_correct};
            ext_sync    <= {ext_sync[0], extended};
            ret_sync    <= {ret_sync[0], retracted};
        end
    end

    assign colour_s    = colour_sync[1];
    assign extended_s  = ext_sync[1];
    assign retracted_s = ret_sync[1];

    // ------------------------------------------------------------------
    // Command queue
    // ------------------------------------------------------------------
    sched_state_t       state;
    sched_state_t       next_state;
    logic [INSTR_W-1:0] fifo_head;
    logic [CW-1:0]      fifo_count;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_flush;

    assign cmd_ready   = (fifo_count < CW'(DEPTH)) && (state != ST_FAULT);
    assign fifo_push   = cmd_valid && cmd_ready;
    assign fifo_pop    = (state == ST_FETCH);
    assign fifo_flush  = (state == ST_FAULT) && fault_clear;
    assign queue_count = fifo_count;
    assign busy        = (state != ST_IDLE) || (fifo_count != '0);

    sched_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (cmd_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .count     (fifo_count)
    );

    // ------------------------------------------------------------------
    // Job engine
    // ------------------------------------------------------------------
    logic [INSTR_W-1:0] instr;
    logic [INSTR_W-1:0] instr_next;
    logic [TW-1:0]      tmo_cnt;
    logic               tmo_hit;
    logic               job_end;
    logic               motion;

    logic               turntable_en_d;
    logic [7:0]         turntable_pos_d;
    logic               track_en_d;
    logic [7:0]         track_pos_d;
    logic               fault_d;
    logic [1:0]         fault_code_d;

    assign tmo_hit    = (tmo_cnt == TMO_LAST);
    assign instr_next = (state == ST_FETCH) ? fifo_head : instr;
    assign motion     = (state == ST_SPIN) || (state == ST_PUSH) || (state == ST_PULL);

    // Next-state logic. In every motion state the exit event is tested
    // before the timeout so a simultaneous arrival completes the motion.
    always_comb begin
        next_state = state;
        job_end    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fifo_count != '0) begin
                    next_state = ST_FETCH;
                end
            end
            ST_FETCH: begin
                next_state = first_motion(fifo_head);
            end
            ST_SPIN: begin
                if (colour_s) begin
                    if (is_sort_job(instr)) begin
                        next_state = ST_PUSH;
                    end else begin
                        next_state = ST_IDLE;
                        job_end    = 1'b1;
                    end
                end else if (tmo_hit) begin
                    next_state = ST_FAULT;
                end
            end
            ST_PUSH: begin
                if (extended_s) begin
                    if (is_sort_job(instr)) begin
                        next_state = ST_PULL;
                    end else begin
                        next_state = ST_IDLE;
                        job_end    = 1'b1;
                    end
                end else if (tmo_hit) begin
                    next_state = ST_FAULT;
                end
            end
            ST_PULL: begin
                if (retracted_s) begin
                    next_state = ST_IDLE;
                    job_end    = 1'b1;
                end else if (tmo_hit) begin
                    next_state = ST_FAULT;
                end
            end
            ST_FAULT: begin
                if (fault_clear) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Output decode works on the state being entered, so the registered
    // outputs change on the same edge as the state register.
    always_comb begin
        turntable_en_d  = 1'b0;
        turntable_pos_d = '0;
        track_en_d      = 1'b0;
        track_pos_d     = TRACK_BWD;
        fault_d         = 1'b0;
        fault_code_d    = FAULT_NONE;
        case (next_state)
            ST_SPIN: begin
                turntable_en_d  = 1'b1;
                turntable_pos_d = instr_next[INSTR_POS_MSB:INSTR_POS_LSB];
            end
            ST_PUSH: begin
                track_en_d  = 1'b1;
                track_pos_d = TRACK_FWD;
            end
            ST_PULL: begin
                track_en_d  = 1'b1;
                track_pos_d = TRACK_BWD;
            end
            ST_FAULT: begin
                fault_d      = 1'b1;
                fault_code_d = (state == ST_FAULT) ? fault_code : fault_code_for(state);
            end
            default: begin
            end
        endcase
    end

    // State, instruction, timeout counter and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            instr         <= '0;
            tmo_cnt       <= '0;
            turntable_en  <= 1'b0;
            turntable_pos <= '0;
            track_en      <= 1'b0;
            track_pos     <= TRACK_BWD;
            job_done      <= 1'b0;
            fault         <= 1'b0;
            fault_code    <= FAULT_NONE;
        end else begin
            state <= next_state;
            instr <= instr_next;
            // Cleared on every state change, so each motion starts from zero;
            // a motion state always leaves by TMO_LAST, so no saturation needed.
            if (next_state != state) begin
                tmo_cnt <= '0;
            end else if (motion) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
            turntable_en  <= turntable_en_d;
            turntable_pos <= turntable_pos_d;
            track_en      <= track_en_d;
            track_pos     <= track_pos_d;
            job_done      <= job_end;
            fault         <= fault_d;
            fault_code    <= fault_code_d;
        end
    end

endmodule

// File: tb/tb_servo_job_scheduler.sv
// Self-checking bench for servo_job_scheduler: directed jobs, a scoreboard of expected job outcomes,
// and a monitor that compares each job_done / fault event against the head of the scoreboard.
module tb_servo_job_scheduler;

    localparam int DEPTH = 4;
    localparam int TMO   = 100;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic [9:0] cmd_data;
    logic       cmd_ready;
    logic       colour_correct;
    logic       extended;
    logic       retracted;
    logic       fault_clear;
    logic       turntable_en;
    logic [7:0] turntable_pos;
    logic       track_en;
    logic [7:0] track_pos;
    logic       busy;
    logic       job_done;
    logic       fault;
    logic [1:0] fault_code;
    logic [2:0] queue_count;

    // Plant inputs: either driven by hand or by a simple reactive plant model
    logic plant_auto;
    logic man_colour, man_extended, man_retracted;
    logic auto_colour, auto_extended, auto_retracted;

    assign colour_correct = plant_auto ? auto_colour    : man_colour;
    assign extended       = plant_auto ? auto_extended  : man_extended;
    assign retracted      = plant_auto ? auto_retracted : man_retracted;

    always #5 clk = ~clk;

    servo_job_scheduler #(
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_data       (cmd_data),
        .cmd_ready      (cmd_ready),
        .colour_correct (colour_correct),
        .extended       (extended),
        .retracted      (retracted),
        .fault_clear    (fault_clear),
        .turntable_en   (turntable_en),
        .turntable_pos  (turntable_pos),
        .track_en       (track_en),
        .track_pos      (track_pos),
        .busy           (busy),
        .job_done       (job_done),
        .fault          (fault),
        .fault_code     (fault_code),
        .queue_count    (queue_count)
    );

    typedef struct {
        bit         is_fault;
        logic [1:0] code;
        bit         spin;
        logic [7:0] pos;
        bit         track;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t rec(input bit f, input logic [1:0] c, input bit s,
                                 input logic [7:0] p, input bit t);
        exp_t e;
        e.is_fault = f;
        e.code     = c;
        e.spin     = s;
        e.pos      = p;
        e.track    = t;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit cond(input int sel);
        bit r;
        case (sel)
            0:       r = turntable_en;
            1:       r = track_en;
            2:       r = job_done;
            3:       r = fault;
            default: r = !busy && (sb.size() == 0);
        endcase
        return r;
    endfunction

    task automatic wait_sig(input int sel, input int budget, input string name, output int cycles);
        cycles = 0;
        while (!cond(sel)) begin
            if (cycles >= budget) begin
                checks++;
                errors++;
                $display("FAIL %s: timed out after %0d cycles", name, cycles);
                return;
            end
            @(negedge clk);
            cycles++;
        end
    endtask

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic send(input logic [9:0] d);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_data  = d;
        while (!cmd_ready) begin
            if (n >= 300) begin
                checks++;
                errors++;
                $display("FAIL send_%0h: cmd_ready stayed low for %0d cycles", d, n);
                cmd_valid = 1'b0;
                return;
            end
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Reactive plant: colour follows the turntable, switches follow the track direction.
    initial begin
        auto_colour    = 1'b0;
        auto_extended  = 1'b0;
        auto_retracted = 1'b1;
        forever begin
            @(negedge clk);
            auto_colour = turntable_en;
            if (track_en && track_pos == 8'hFF) begin
                auto_extended  = 1'b1;
                auto_retracted = 1'b0;
            end else if (track_en && track_pos == 8'h00) begin
                auto_extended  = 1'b0;
                auto_retracted = 1'b1;
            end
        end
    end

    // Monitor: tracks what the current job did and checks it at completion/fault.
    initial begin
        bit         cur_spin;
        bit         cur_track;
        bit         fault_q;
        logic [7:0] cur_pos;
        exp_t       e;
        cur_spin  = 1'b0;
        cur_track = 1'b0;
        fault_q   = 1'b0;
        cur_pos   = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                cur_spin  = 1'b0;
                cur_track = 1'b0;
                fault_q   = 1'b0;
                cur_pos   = '0;
            end else begin
                if (turntable_en) begin
                    cur_spin = 1'b1;
                    cur_pos  = turntable_pos;
                end
                if (track_en) begin
                    cur_track = 1'b1;
                end
                if (job_done || (fault && !fault_q)) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_unexpected: job_done=%0b fault=%0b with no job expected", job_done, fault);
                    end else begin
                        e = sb.pop_front();
                        check("sb_kind", fault, e.is_fault);
                        if (e.is_fault) begin
                            check("sb_fault_code", fault_code, e.code);
                        end else begin
                            check("sb_spin_used", cur_spin, e.spin);
                            if (e.spin) check("sb_spin_pos", cur_pos, e.pos);
                            check("sb_track_used", cur_track, e.track);
                        end
                    end
                    cur_spin  = 1'b0;
                    cur_track = 1'b0;
                    cur_pos   = '0;
                end
                fault_q = fault;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        reset         = 1'b1;
        cmd_valid     = 1'b0;
        cmd_data      = '0;
        fault_clear   = 1'b0;
        man_colour    = 1'b0;
        man_extended  = 1'b0;
        man_retracted = 1'b1;
        plant_auto    = 1'b0;
        repeat (3) @(negedge clk);

        // ---- reset state ----
        check("rst_enables", {turntable_en, track_en}, 0);
        check("rst_pos", {turntable_pos, track_pos}, 0);
        check("rst_status", {busy, fault, fault_code, job_done}, 0);
        check("rst_queue", queue_count, 0);
        check("rst_ready", cmd_ready, 1);
        reset = 1'b0;
        @(negedge clk);

        // ---- sort job 0x080 with exact pipeline timing ----
        sb.push_back(rec(0, 2'b00, 1, 8'h80, 1));
        send(10'h080);
        check("a_queued", queue_count, 1);
        check("a_busy", busy, 1);
        check("a_idle_tt", turntable_en, 0);
        @(negedge clk);
        check("a_fetch_tt", turntable_en, 0);
        @(negedge clk);
        check("a_spin_en", {turntable_en, track_en}, 2'b10);
        check("a_spin_pos", turntable_pos, 8'h80);
        check("a_spin_q", queue_count, 0);
        man_colour = 1'b1;
        repeat (2) @(negedge clk);
        check("a_sync_lat", turntable_en, 1);
        @(negedge clk);
        check("a_push_en", {turntable_en, track_en}, 2'b01);
        check("a_push_pos", track_pos, 8'hFF);
        man_colour    = 1'b0;
        man_extended  = 1'b1;
        man_retracted = 1'b0;
        repeat (2) @(negedge clk);
        check("a_push_hold", track_pos, 8'hFF);
        @(negedge clk);
        check("a_pull", {track_en, track_pos}, 9'h100);
        man_extended  = 1'b0;
        man_retracted = 1'b1;
        repeat (3) @(negedge clk);
        check("a_done", job_done, 1);
        check("a_done_en", {turntable_en, track_en}, 0);
        @(negedge clk);
        check("a_done_pulse", job_done, 0);
        check("a_idle", busy, 0);

        // ---- maintenance spin 0x3A5 ----
        sb.push_back(rec(0, 2'b00, 1, 8'hA5, 0));
        send(10'h3A5);
        wait_sig(0, 10, "f_spin", cyc);
        check("f_pos", turntable_pos, 8'hA5);
        check("f_track", track_en, 0);
        man_colour = 1'b1;
        wait_sig(2, 10, "f_done", cyc);
        check("f_done_en", {turntable_en, track_en}, 0);
        man_colour = 1'b0;
        repeat (3) @(negedge clk);

        // ---- backpressure: stall in SPIN, fill queue, hold a 5th command ----
        sb.push_back(rec(0, 2'b00, 1, 8'h11, 1));
        send(10'h011);
        wait_sig(0, 10, "b_spin", cyc);
        sb.push_back(rec(0, 2'b00, 1, 8'hC1, 0));
        send(10'h3C1);
        sb.push_back(rec(0, 2'b00, 0, 8'h00, 1));
        send(10'h280);
        sb.push_back(rec(0, 2'b00, 0, 8'h00, 1));
        send(10'h200);
        sb.push_back(rec(0, 2'b00, 1, 8'h55, 1));
        send(10'h155);
        check("b_full_q", queue_count, 4);
        check("b_full_rdy", cmd_ready, 0);
        sb.push_back(rec(0, 2'b00, 1, 8'hEE, 0));
        cmd_valid = 1'b1;
        cmd_data  = 10'h3EE;
        repeat (5) @(negedge clk);
        check("b_hold_q", queue_count, 4);
        check("b_hold_rdy", cmd_ready, 0);
        plant_auto = 1'b1;
        send(10'h3EE);
        check("b_refill_q", queue_count, 4);
        wait_sig(4, 2000, "b_drain", cyc);
        plant_auto    = 1'b0;
        man_colour    = 1'b0;
        man_extended  = 1'b0;
        man_retracted = 1'b1;
        repeat (3) @(negedge clk);

        // ---- push-only job times out; queued job flushed on clear ----
        sb.push_back(rec(1, 2'b10, 0, 8'h00, 0));
        send(10'h280);
        send(10'h3B0);
        wait_sig(1, 20, "c_push", cyc);
        wait_sig(3, 200, "c_fault", cyc);
        check("c_tmo_cycles", cyc, TMO);
        check("c_code", fault_code, 2'b10);
        check("c_en", {turntable_en, track_en}, 0);
        check("c_pos", track_pos, 8'h00);
        check("c_rdy", cmd_ready, 0);
        check("c_q", queue_count, 1);
        repeat (3) @(negedge clk);
        check("c_hold", fault, 1);
        fault_clear = 1'b1;
        @(negedge clk);
        fault_clear = 1'b0;
        check("c_clr_q", queue_count, 0);
        check("c_clr_fault", {fault, fault_code}, 0);
        check("c_clr_rdy", cmd_ready, 1);
        check("c_clr_busy", busy, 0);

        // ---- retracted arrives in the same cycle as the PULL timeout ----
        man_retracted = 1'b0;
        @(negedge clk);
        sb.push_back(rec(0, 2'b00, 0, 8'h00, 1));
        send(10'h200);
        wait_sig(1, 20, "d_pull", cyc);
        repeat (97) @(negedge clk);
        man_retracted = 1'b1;
        repeat (2) @(negedge clk);
        check("d_pre", {track_en, job_done, fault}, 3'b100);
        @(negedge clk);
        check("d_done", job_done, 1);
        check("d_nofault", fault, 0);
        repeat (2) @(negedge clk);

        // ---- reset during PUSH with two queued jobs ----
        man_extended = 1'b0;
        send(10'h280);
        send(10'h3AA);
        send(10'h200);
        check("e_push", track_en, 1);
        check("e_q", queue_count, 2);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        check("e_rst_en", {turntable_en, track_en, job_done, fault}, 0);
        check("e_rst_q", queue_count, 0);
        check("e_rst_pos", track_pos, 8'h00);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("e_stays_idle", {busy, track_en, turntable_en}, 0);

        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
